acc_issue_unit: RTL and testbench
=================================

Name: acc_issue_unit

Overview:
- Sits directly downstream of the decode/control stage.
- Takes decoded accelerator-extension instructions (opcode INST_ACC, op chosen by funct3) together with their register operands. Buffers them in a small in-order command queue and issues them to the matrix accelerator over a valid/ready handshake.
- Tracks commands that have been issued but not yet completed.
- Stalls the decode stage when the queue is full, or when a core load/store must be ordered behind pending accelerator work.

Parameters:
- QUEUE_DEPTH, 4: command queue entries; power of two, minimum 2.
- MAX_OUTSTANDING, 7: maximum issued-but-not-done commands; the counter is 3 bits wide.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode stage holds a valid instruction this cycle.
- accelerator_instr  in  1  instruction is an accelerator instruction.
- instr_funct3  in  3  accelerator op: LOAD=0, SAVE=1, MATMUL=2, RESET=3, MOVE=4 (the defines-file encodings); 5-7 undefined.
- mem_read  in  1  core memory read (control-unit output).
- mem_write  in  1  core memory write (control-unit output).
- rs1_data  in  32  rs1 value; the command memory address.
- rs2_data  in  32  rs2 value; the command argument.
- stall  out  1  hold decode and all upstream stages this cycle.
- acc_cmd_valid  out  1  command presented to the accelerator.
- acc_cmd_ready  in  1  accelerator accepts the command.
- acc_cmd_op  out  3  funct3 of the head command.
- acc_cmd_addr  out  32  rs1 of the head command.
- acc_cmd_arg  out  32  rs2 of the head command.
- acc_done  in  1  one-cycle pulse per completed command.
- acc_busy  out  1  queue non-empty or outstanding count non-zero.
- illegal_acc  out  1  one-cycle pulse for an undefined accelerator funct3.

Behaviour:
- Reset:
  - queue empty, read/write pointers 0, outstanding 0, illegal_acc 0.
  - Consequently stall, acc_cmd_valid and acc_busy are 0; acc_cmd_op/addr/arg are 0.
  - Reset mid-operation discards all queued entries and clears outstanding. acc_done pulses arriving after reset while outstanding=0 are ignored, and the counter stays 0.
- Queue state: count, wr_ptr and rd_ptr are registered; pointers wrap modulo QUEUE_DEPTH.
- Enqueue:
  - Condition: id_valid & accelerator_instr & funct3<=4 & !stall.
  - Writes {funct3, rs1_data, rs2_data} at wr_ptr.
- Illegal funct3:
  - id_valid & accelerator_instr & funct3>=5 is not enqueued and does not stall.
  - illegal_acc is asserted for exactly one cycle, in the cycle after.
- Stall (combinational from inputs and registered state only; never depends on acc_cmd_ready or acc_done):
  - Condition A: id_valid & accelerator_instr & legal funct3 & count==QUEUE_DEPTH. A same-cycle dequeue does not relieve this stall.
  - Condition B: id_valid & !accelerator_instr & (mem_read|mem_write) & acc_busy. This is memory ordering: core loads/stores wait until every accelerator command is done.
  - id_valid=0 gives stall=0.
- Issue:
  - acc_cmd_valid = (count!=0) & (outstanding<MAX_OUTSTANDING).
  - acc_cmd_op/addr/arg come from the entry at rd_ptr.
  - Outputs are held stable while valid & !ready.
  - valid & ready in a cycle: rd_ptr++, count--, outstanding++.
- Latency: a command enqueued in cycle N is presented at the earliest in cycle N+1. A back-to-back ready accelerator issues one command per cycle.
- Simultaneous events:
  - enqueue and dequeue in one cycle: count unchanged.
  - issue and acc_done in one cycle: outstanding unchanged.
  - acc_done with outstanding=0 and no same-cycle issue: ignored.
- Ordering: strictly in order. RESET and MOVE are ordinary commands with no special handling.
- acc_busy: derived from registered state only; it drops in the cycle after the last acc_done is absorbed.

Test Plan:
- Reset then idle: hold rst for 2 cycles.
  - Expected: stall, acc_cmd_valid, acc_busy, illegal_acc and outstanding are all 0.
- Single LOAD:
  - Stimulus: funct3=0, rs1=0x1000, rs2=0x10, acc_cmd_ready=1.
  - Expected: next cycle acc_cmd_valid=1, op=0, addr=0x1000, arg=0x10. outstanding=1 after the handshake. acc_done returns busy to 0 one cycle later.
- Queue full:
  - Stimulus: acc_cmd_ready=0; enqueue 4 MATMULs; then present a 5th.
  - Expected: stall=1 with queue unchanged. Raising ready pops one entry; the 5th enqueues the following cycle. Issue order is preserved (compare the rs1 sequence).
- Memory ordering:
  - Stimulus: one SAVE outstanding, then a core LW (mem_read=1) is presented.
  - Expected: stall=1 until the cycle after acc_done, then stall=0.
- Outstanding limit:
  - Stimulus: issue 7 commands with no acc_done.
  - Expected: acc_cmd_valid=0 with the 8th command queued. One acc_done re-asserts valid next cycle.
- Illegal funct3 and reset mid-op:
  - Stimulus: funct3=6, then queue 3 commands and assert rst.
  - Expected: illegal_acc pulses for 1 cycle and nothing is enqueued. After reset the queue is empty and acc_cmd_valid=0.

Source files
------------

// File: rtl/acc_issue_unit_if.sv
// rtl/acc_issue_unit_if.sv - decode-side and accelerator-side signal bundle for acc_issue_unit
//
// Purpose: groups the decode inputs, the stall output, the accelerator command
// handshake and the completion/status signals of the issue unit.
// Ports (signals):
//   decode side : id_valid, accelerator_instr, instr_funct3, mem_read, mem_write,
//                 rs1_data, rs2_data -> stall
//   command     : acc_cmd_valid, acc_cmd_op, acc_cmd_addr, acc_cmd_arg <- acc_cmd_ready
//   completion  : acc_done -> acc_busy, illegal_acc
// Modports: slave = the issue unit, master = the environment driving it.
interface acc_issue_unit_if;
    logic        id_valid;
    logic        accelerator_instr;
    logic [2:0]  instr_funct3;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        stall;
    logic        acc_cmd_valid;
    logic        acc_cmd_ready;
    logic [2:0]  acc_cmd_op;
    logic [31:0] acc_cmd_addr;
    logic [31:0] acc_cmd_arg;
    logic        acc_done;
    logic        acc_busy;
    logic        illegal_acc;

    modport slave (
        input  id_valid, accelerator_instr, instr_funct3, mem_read, mem_write,
               rs1_data, rs2_data, acc_cmd_ready, acc_done,
        output stall, acc_cmd_valid, acc_cmd_op, acc_cmd_addr, acc_cmd_arg,
               acc_busy, illegal_acc
    );

    modport master (
        output id_valid, accelerator_instr, instr_funct3, mem_read, mem_write,
               rs1_data, rs2_data, acc_cmd_ready, acc_done,
        input  stall, acc_cmd_valid, acc_cmd_op, acc_cmd_addr, acc_cmd_arg,
               acc_busy, illegal_acc
    );
endinterface

// File: rtl/acc_issue_unit.sv
// rtl/acc_issue_unit.sv - in-order accelerator command queue with issue, outstanding tracking and decode stall
//
// Purpose: buffers decoded accelerator instructions, issues them in order to the
// matrix accelerator, counts issued-but-not-done commands and stalls decode when
// the queue is full or a core load/store must wait for accelerator work.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - acc_issue_unit_if.slave (decode inputs, stall, command handshake,
//          acc_done, acc_busy, illegal_acc)
module acc_issue_unit #(
    parameter int QUEUE_DEPTH     = 4,
    parameter int MAX_OUTSTANDING = 7
) (
    input  logic           clk,
    input  logic           rst,
    acc_issue_unit_if.slave bus
);
    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [2:0]    r_q_op   [QUEUE_DEPTH];
    logic [31:0]   r_q_addr [QUEUE_DEPTH];
    logic [31:0]   r_q_arg  [QUEUE_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [2:0]    r_outstanding;
    logic          r_illegal;

    logic w_acc_req;
    logic w_legal;
    logic w_full;
    logic w_busy;
    logic w_stall;
    logic w_enq;
    logic w_valid;
    logic w_issue;

    assign w_acc_req = bus.id_valid & bus.accelerator_instr;
    assign w_legal   = (bus.instr_funct3 <= 3'd4);
    assign w_full    = (r_count == CW'(QUEUE_DEPTH));
    assign w_busy    = (r_count != '0) | (r_outstanding != 3'd0);

    // Full-queue stall uses only registered count so a same-cycle dequeue never
    // releases it; the memory-ordering stall holds core loads/stores until all
    // accelerator work has drained.
    assign w_stall = (w_acc_req & w_legal & w_full)
                   | (bus.id_valid & ~bus.accelerator_instr
                      & (bus.mem_read | bus.mem_write) & w_busy);

    assign w_enq   = w_acc_req & w_legal & ~w_stall;
    assign w_valid = (r_count != '0) & (r_outstanding < 3'(MAX_OUTSTANDING));
    assign w_issue = w_valid & bus.acc_cmd_ready;

    assign bus.stall         = w_stall;
    assign bus.acc_cmd_valid = w_valid;
    assign bus.acc_cmd_op    = r_q_op[r_rd_ptr];
    assign bus.acc_cmd_addr  = r_q_addr[r_rd_ptr];
    assign bus.acc_cmd_arg   = r_q_arg[r_rd_ptr];
    assign bus.acc_busy      = w_busy;
    assign bus.illegal_acc   = r_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            // Storage is cleared too so the head outputs read 0 out of reset.
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                r_q_op[i]   <= 3'd0;
                r_q_addr[i] <= 32'd0;
                r_q_arg[i]  <= 32'd0;
            end
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= 3'd0;
            r_illegal     <= 1'b0;
        end else begin
            if (w_enq) begin
                r_q_op[r_wr_ptr]   <= bus.instr_funct3;
                r_q_addr[r_wr_ptr] <= bus.rs1_data;
                r_q_arg[r_wr_ptr]  <= bus.rs2_data;
                r_wr_ptr           <= r_wr_ptr + PW'(1);
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end

            case ({w_enq, w_issue})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // A completion with nothing outstanding (and no issue to pair with)
            // is stray and dropped, keeping the counter from wrapping.
            if (w_issue && !bus.acc_done) begin
                r_outstanding <= r_outstanding + 3'd1;
            end else if (!w_issue && bus.acc_done && (r_outstanding != 3'd0)) begin
                r_outstanding <= r_outstanding - 3'd1;
            end

            r_illegal <= w_acc_req & ~w_legal;
        end
    end
endmodule

// File: tb/tb_acc_issue_unit.sv
// tb/tb_acc_issue_unit.sv - directed and randomized bench for acc_issue_unit against a queue-based reference model
module tb_acc_issue_unit;
    localparam int QD   = 4;
    localparam int MAXO = 7;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] arg;
    } cmd_t;

    logic clk;
    logic rst;
    acc_issue_unit_if bus_if ();

    acc_issue_unit #(.QUEUE_DEPTH(QD), .MAX_OUTSTANDING(MAXO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cmd_t mq[$];
    int   m_out;
    bit   m_ill;
    bit   m_fresh;
    int   n_tests;
    int   n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit a, input logic [2:0] f,
                        input bit mr, input bit mw, input logic [31:0] d1,
                        input logic [31:0] d2, input bit rdy, input bit dn);
        bit   legal, e_busy, e_valid, e_stall, iss, enq;
        cmd_t c;
        @(negedge clk);
        rst                      = r;
        bus_if.id_valid          = v;
        bus_if.accelerator_instr = a;
        bus_if.instr_funct3      = f;
        bus_if.mem_read          = mr;
        bus_if.mem_write         = mw;
        bus_if.rs1_data          = d1;
        bus_if.rs2_data          = d2;
        bus_if.acc_cmd_ready     = rdy;
        bus_if.acc_done          = dn;
        #1;
        legal   = (f <= 3'd4);
        e_busy  = (mq.size() != 0) || (m_out != 0);
        e_valid = (mq.size() != 0) && (m_out < MAXO);
        e_stall = (v && a && legal && mq.size() == QD) || (v && !a && (mr || mw) && e_busy);
        if (!r) begin
            check("stall", {31'd0, bus_if.stall}, {31'd0, e_stall});
            check("valid", {31'd0, bus_if.acc_cmd_valid}, {31'd0, e_valid});
            check("busy", {31'd0, bus_if.acc_busy}, {31'd0, e_busy});
            check("illegal", {31'd0, bus_if.illegal_acc}, {31'd0, m_ill});
            if (mq.size() != 0) begin
                check("op", {29'd0, bus_if.acc_cmd_op}, {29'd0, mq[0].op});
                check("addr", bus_if.acc_cmd_addr, mq[0].addr);
                check("arg", bus_if.acc_cmd_arg, mq[0].arg);
            end else if (m_fresh) begin
                check("op_rst", {29'd0, bus_if.acc_cmd_op}, 32'd0);
                check("addr_rst", bus_if.acc_cmd_addr, 32'd0);
                check("arg_rst", bus_if.acc_cmd_arg, 32'd0);
            end
        end
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_out   = 0;
            m_ill   = 1'b0;
            m_fresh = 1'b1;
        end else begin
            iss = e_valid && rdy;
            enq = v && a && legal && !e_stall;
            if (iss) void'(mq.pop_front());
            if (enq) begin
                c.op   = f;
                c.addr = d1;
                c.arg  = d2;
                mq.push_back(c);
                m_fresh = 1'b0;
            end
            if (iss && !dn) m_out++;
            else if (!iss && dn && m_out > 0) m_out--;
            m_ill = v && a && !legal;
        end
    endtask

    task automatic idle(input bit rdy, input bit dn);
        step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, rdy, dn);
    endtask

    task automatic acc(input logic [2:0] f, input logic [31:0] d1, input logic [31:0] d2,
                       input bit rdy, input bit dn);
        step(1'b0, 1'b1, 1'b1, f, 1'b0, 1'b0, d1, d2, rdy, dn);
    endtask

    initial begin
        int done_pct;
        n_tests = 0;
        n_fail  = 0;
        m_out   = 0;
        m_ill   = 1'b0;
        m_fresh = 1'b1;
        rst                      = 1'b1;
        bus_if.id_valid          = 1'b0;
        bus_if.accelerator_instr = 1'b0;
        bus_if.instr_funct3      = 3'd0;
        bus_if.mem_read          = 1'b0;
        bus_if.mem_write         = 1'b0;
        bus_if.rs1_data          = 32'd0;
        bus_if.rs2_data          = 32'd0;
        bus_if.acc_cmd_ready     = 1'b0;
        bus_if.acc_done          = 1'b0;

        // Reset then idle
        step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);

        // Single LOAD, then completion
        acc(3'd0, 32'h1000, 32'h10, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b0);

        // Queue full with ready low, then release one entry
        for (int k = 0; k < 4; k++) acc(3'd2, 32'h100 * (k + 1), 32'(k), 1'b0, 1'b0);
        acc(3'd2, 32'h500, 32'd4, 1'b0, 1'b0);
        acc(3'd2, 32'h500, 32'd4, 1'b1, 1'b0);
        acc(3'd2, 32'h500, 32'd4, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) idle(1'b1, 1'b1);

        // Memory ordering: SAVE outstanding, core LW waits for acc_done
        acc(3'd1, 32'h2000, 32'h20, 1'b1, 1'b0);
        idle(1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Outstanding limit: 8 commands, no completions
        for (int k = 0; k < 8; k++) acc(3'(k % 5), 32'h3000 + 32'(k), 32'(k), 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) idle(1'b1, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);
        for (int k = 0; k < 9; k++) idle(1'b1, 1'b1);

        // Illegal funct3, then reset with commands queued
        acc(3'd6, 32'hdead, 32'hbeef, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) acc(3'(k + 2), 32'h4000 + 32'(k), 32'(k), 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        idle(1'b1, 1'b1);
        idle(1'b1, 1'b0);

        // Randomized traffic with varying completion rate
        for (int i = 0; i < 3000; i++) begin
            bit       r, v, a, mr, mw, rdy, dn;
            logic [2:0] f;
            done_pct = (i / 300) % 3 == 0 ? 5 : ((i / 300) % 3 == 1 ? 40 : 75);
            r   = ($urandom_range(0, 299) == 0);
            v   = ($urandom_range(0, 3) != 0);
            a   = ($urandom_range(0, 3) != 0);
            f   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            mr  = ($urandom_range(0, 3) == 0);
            mw  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            dn  = ($urandom_range(0, 99) < done_pct);
            step(r, v, a, f, mr, mw, $urandom, $urandom, rdy, dn);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
